spi_target_regs: RTL and testbench
==================================

# spi_target_regs

SPI target (responder) with a small byte-wide register file. It is the far end of the bridge's SPI master and serves as the on-chip loopback target and bench partner for the I2C-to-SPI path. SCK, CS_n and MOSI are oversampled in the system clock domain. The block decodes mode-0, MSB-first command/data frames, writes or reads an internal register file with address auto-increment, and drives MISO.

## Interface
Parameters:
- NUM_REGS, 8: number of 8-bit registers. Power of two, 2..16.
- ADDR_W, 3: address width. Equals log2(NUM_REGS).

Ports:
- clk, input, 1: system clock. Must be at least 8× the SCK frequency.
- rst_n, input, 1: asynchronous, active-low reset.
- sck_i, input, 1: SPI clock, asynchronous to clk. CPOL=0.
- cs_n_i, input, 1: chip select, active low, asynchronous.
- mosi_i, input, 1: serial data from the master, asynchronous.
- miso_o, output, 1: serial data to the master.
- miso_oe, output, 1: MISO output enable. High while CS is synchronized-active.
- regs_o, output, NUM_REGS*8: flat register contents. reg[k] is at bits [8k+7:8k].
- wr_strobe_o, output, 1: one-cycle pulse when a register is written.
- wr_addr_o, output, ADDR_W: address of the last write.
- busy_o, output, 1: high when the FSM is not in IDLE.

## Operation
- sck_i, cs_n_i and mosi_i each pass through a 2-flop synchronizer. sck_i also gets a rise/fall edge detector on the synchronized value.
- Mode 0:
  - MOSI is sampled on each detected SCK rise.
  - MISO shifts on each detected SCK fall. MSB first.
- Frame: command byte, then 0..n data bytes.
  - cmd[7] = 1 means read, 0 means write.
  - cmd[ADDR_W-1:0] is the start address. Other bits are ignored.
- FSM states: IDLE, CMD, WR_DATA, RD_DATA.
  - IDLE -> CMD on synchronized CS falling. Bit counter cleared. MISO shift register loaded with 0x00.
  - CMD -> WR_DATA or RD_DATA after the 8th rise. The address pointer is loaded from the command.
  - On entry to RD_DATA, the shift register is loaded with reg[ptr] and ptr increments. The MSB drives MISO at the 8th fall.
  - WR_DATA, after each 8th rise:
    - reg[ptr] <= received byte.
    - wr_strobe_o pulses.
    - wr_addr_o <= ptr.
    - ptr increments.
  - RD_DATA, after each 8th rise: the shift register reloads with reg[ptr] and ptr increments.
  - Any state -> IDLE on synchronized CS high.
- ptr increments modulo NUM_REGS, so it wraps from NUM_REGS-1 to 0.
- CS deasserted mid-byte: the partial byte is discarded, with no write and no strobe. A byte completed before CS rose is kept.
- CS rise and the 8th rise detected in the same cycle: the completed byte is committed first, then the FSM goes to IDLE.
- SCK edges are ignored while in IDLE.
- MISO during the command byte is 0x00.
- miso_o is 0 whenever miso_oe is 0.

## Timing
- Reset values:
  - regs_o = 0, miso_o = 0, miso_oe = 0.
  - wr_strobe_o = 0, wr_addr_o = 0, busy_o = 0.
  - FSM = IDLE, ptr = 0, bit counter = 0.
- Synchronizer plus edge detect gives 3 clk from a pin transition to the internal edge pulse.
- miso_o updates 4 clk after the SCK-fall pin transition. This is within the half-period at clk ≥ 8×SCK.
- wr_strobe_o and the regs_o update occur 4 clk after the 8th SCK-rise pin transition.
- miso_oe follows synchronized CS: rises 2 clk after CS falls and falls 2 clk after CS rises.
- Back-to-back frames require CS high for at least 3 clk.
- Reset asserted mid-frame clears everything immediately, including regs_o. The frame in progress is lost.

## Structure
- Package spi_target_pkg holds:
  - the state enum (IDLE, CMD, WR_DATA, RD_DATA);
  - CMD_RD_BIT = 7;
  - BYTE_W = 8.
- Sub-module sync_edge: 2-flop synchronizer with rise/fall pulse outputs. Three instances: SCK, CS, MOSI. Only SCK uses the edge outputs; CS edges are derived from its level.
- Top level: FSM, bit counter, RX/TX shift registers, pointer, register array.

## Test plan
- Write burst: cmd 0x02, data 0x11 0x22 0x33 -> reg2=0x11, reg3=0x22, reg4=0x33; three wr_strobe_o pulses with wr_addr_o 2,3,4; other registers stay 0.
- Read back: after the burst, cmd 0x82 plus 3 dummy bytes -> MISO bytes 0x00, 0x11, 0x22, 0x33; miso_oe high for the whole frame.
- Wrap: cmd 0x07, data 0xAA 0xBB -> reg7=0xAA, reg0=0xBB; read cmd 0x87 returns 0xAA then 0xBB.
- Abort: cmd 0x01, 5 bits of 0xF0, then CS high -> no strobe, reg1 unchanged; the next frame, cmd 0x81, reads the old reg1 value.
- Async reset mid-read (cmd 0x80, 4 data bits in) -> all outputs 0 within the reset cycle, busy_o=0, regs_o=0.
- Speed corner: clk = 8×SCK, 4-byte write then read -> data matches bit-exact; no missed or double edges.

Source files
------------

// File: rtl/spi_target_pkg.sv
// rtl/spi_target_pkg.sv - shared types and constants for the SPI register target
package spi_target_pkg;

    typedef enum logic [1:0] {
        IDLE,
        CMD,
        WR_DATA,
        RD_DATA
    } state_t;

    localparam int CMD_RD_BIT = 7;
    localparam int BYTE_W     = 8;

endpackage

// File: rtl/spi_target_regs_if.sv
// rtl/spi_target_regs_if.sv - SPI pin bundle between a master and the register target
interface spi_target_regs_if;

    logic sck_i;
    logic cs_n_i;
    logic mosi_i;
    logic miso_o;
    logic miso_oe;

    modport master (output sck_i, output cs_n_i, output mosi_i, input miso_o, input miso_oe);
    modport slave  (input sck_i, input cs_n_i, input mosi_i, output miso_o, output miso_oe);

endinterface

// File: rtl/spi_target_regs_sync_edge.sv
// rtl/spi_target_regs_sync_edge.sv - 2-flop synchronizer with registered rise/fall pulses
module sync_edge #(
    parameter logic RST_VAL = 1'b0
) (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic q,
    output logic rise,
    output logic fall
);

    logic s1, s2, s3;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1   <= RST_VAL;
            s2   <= RST_VAL;
            s3   <= RST_VAL;
            rise <= 1'b0;
            fall <= 1'b0;
        end else begin
            s1   <= d;
            s2   <= s1;
            s3   <= s2;
            rise <= s2 & ~s3;
            fall <= ~s2 & s3;
        end
    end

    assign q = s2;

endmodule

// File: rtl/spi_target_regs.sv
// rtl/spi_target_regs.sv - mode-0 SPI target with an auto-incrementing byte register file
module spi_target_regs
    import spi_target_pkg::*;
#(
    parameter int NUM_REGS = 8,
    parameter int ADDR_W   = 3
) (
    input  logic                       clk,
    input  logic                       rst_n,
    spi_target_regs_if.slave           spi,
    output logic [NUM_REGS*BYTE_W-1:0] regs_o,
    output logic                       wr_strobe_o,
    output logic [ADDR_W-1:0]          wr_addr_o,
    output logic                       busy_o
);

    logic sck_s, sck_rise, sck_fall;
    logic cs_s, cs_rise_unused, cs_fall_unused;
    logic mosi_s, mosi_rise_unused, mosi_fall_unused;
    logic sck_level_unused;

    sync_edge #(.RST_VAL(1'b0)) u_sck (
        .clk(clk), .rst_n(rst_n), .d(spi.sck_i), .q(sck_s), .rise(sck_rise), .fall(sck_fall)
    );
    sync_edge #(.RST_VAL(1'b1)) u_cs (
        .clk(clk), .rst_n(rst_n), .d(spi.cs_n_i), .q(cs_s), .rise(cs_rise_unused), .fall(cs_fall_unused)
    );
    sync_edge #(.RST_VAL(1'b0)) u_mosi (
        .clk(clk), .rst_n(rst_n), .d(spi.mosi_i), .q(mosi_s), .rise(mosi_rise_unused), .fall(mosi_fall_unused)
    );
    assign sck_level_unused = sck_s;

    state_t              state;
    logic [2:0]          bit_cnt;
    logic [BYTE_W-1:0]   rx_sr;
    logic [BYTE_W-1:0]   tx_sr;
    logic                miso_bit;
    logic [ADDR_W-1:0]   ptr;
    logic [BYTE_W-1:0]   regs [NUM_REGS];

    logic                cs_active;
    logic                byte_done;
    logic [BYTE_W-1:0]   rx_byte;
    logic [ADDR_W-1:0]   cmd_addr;

    assign cs_active = ~cs_s;
    assign byte_done = sck_rise && (bit_cnt == 3'd7) && (state != IDLE);
    assign rx_byte   = {rx_sr[BYTE_W-2:0], mosi_s};
    assign cmd_addr  = rx_byte[ADDR_W-1:0];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            bit_cnt     <= '0;
            rx_sr       <= '0;
            tx_sr       <= '0;
            miso_bit    <= 1'b0;
            ptr         <= '0;
            wr_strobe_o <= 1'b0;
            wr_addr_o   <= '0;
            for (int k = 0; k < NUM_REGS; k++) regs[k] <= '0;
        end else begin
            wr_strobe_o <= 1'b0;
            if (state == IDLE) begin
                if (cs_active) begin
                    state    <= CMD;
                    bit_cnt  <= '0;
                    tx_sr    <= '0;
                    miso_bit <= 1'b0;
                end
            end else begin
                if (sck_rise) begin
                    bit_cnt <= bit_cnt + 3'd1;
                    rx_sr   <= rx_byte;
                end
                // MISO is held in its own flop so a byte loaded at the 8th rise first appears at the following fall
                if (sck_fall) begin
                    miso_bit <= tx_sr[BYTE_W-1];
                    tx_sr    <= {tx_sr[BYTE_W-2:0], 1'b0};
                end
                if (byte_done) begin
                    case (state)
                        CMD: begin
                            if (rx_byte[CMD_RD_BIT]) begin
                                state <= RD_DATA;
                                tx_sr <= regs[cmd_addr];
                                ptr   <= cmd_addr + 1'b1;
                            end else begin
                                state <= WR_DATA;
                                ptr   <= cmd_addr;
                            end
                        end
                        WR_DATA: begin
                            regs[ptr]   <= rx_byte;
                            wr_strobe_o <= 1'b1;
                            wr_addr_o   <= ptr;
                            ptr         <= ptr + 1'b1;
                        end
                        RD_DATA: begin
                            tx_sr <= regs[ptr];
                            ptr   <= ptr + 1'b1;
                        end
                        default: ;
                    endcase
                end
                // CS release wins over any state change, but a byte completing in the same cycle is still committed
                if (!cs_active) state <= IDLE;
            end
        end
    end

    always_comb begin
        regs_o = '0;
        for (int k = 0; k < NUM_REGS; k++) regs_o[k*BYTE_W +: BYTE_W] = regs[k];
    end

    assign busy_o      = (state != IDLE);
    assign spi.miso_oe = cs_active;
    assign spi.miso_o  = cs_active & miso_bit;

endmodule

// File: tb/tb_spi_target_regs.sv
// tb/tb_spi_target_regs.sv - directed table-driven bench for spi_target_regs
module tb_spi_target_regs;

    logic        clk;
    logic        rst_n;
    logic [63:0] regs_o;
    logic        wr_strobe_o;
    logic [2:0]  wr_addr_o;
    logic        busy_o;

    spi_target_regs_if sif ();

    spi_target_regs #(.NUM_REGS(8), .ADDR_W(3)) dut (
        .clk(clk), .rst_n(rst_n), .spi(sif.slave),
        .regs_o(regs_o), .wr_strobe_o(wr_strobe_o), .wr_addr_o(wr_addr_o), .busy_o(busy_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    int         stb_cnt = 0;
    logic [2:0] stb_log [64];

    always @(negedge clk) begin
        if (wr_strobe_o === 1'b1) begin
            if (stb_cnt < 64) stb_log[stb_cnt] = wr_addr_o;
            stb_cnt = stb_cnt + 1;
        end
    end

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks = checks + 1;
        if (act !== exp) begin
            errors = errors + 1;
            $display("FAIL %s actual=%h required=%h", nm, act, exp);
        end
    endtask

    task automatic wait_clks(input int n);
        repeat (n) @(negedge clk);
    endtask

    logic [4:0][7:0] cur_tx;
    logic [4:0][7:0] cur_rx;
    int              oe_bad;

    task automatic do_frame(input int nbits, input int hp, input bit release_cs);
        oe_bad       = 0;
        cur_rx       = '0;
        sif.cs_n_i   = 1'b0;
        for (int j = 0; j < nbits; j++) begin
            sif.mosi_i = cur_tx[j/8][7-(j%8)];
            wait_clks(hp);
            if (sif.miso_oe !== 1'b1) oe_bad = oe_bad + 1;
            cur_rx[j/8][7-(j%8)] = sif.miso_o;
            sif.sck_i = 1'b1;
            wait_clks(hp);
            sif.sck_i = 1'b0;
        end
        if (release_cs) begin
            wait_clks(hp);
            sif.cs_n_i = 1'b1;
            wait_clks(6);
        end
    endtask

    typedef struct {
        int              nb;
        int              hp;
        logic [4:0][7:0] tx;
        logic [4:0][7:0] exp_rx;
        int              nstb;
        logic [3:0][2:0] saddr;
    } vec_t;

    vec_t tbl [6];
    int   stb0;

    initial begin
        // byte 0 is the command; concatenations list the last byte first
        tbl[0] = '{4, 6, {8'h00, 8'h33, 8'h22, 8'h11, 8'h02}, '0, 3, {3'd0, 3'd4, 3'd3, 3'd2}};
        tbl[1] = '{4, 6, {8'h00, 8'h00, 8'h00, 8'h00, 8'h82}, {8'h00, 8'h33, 8'h22, 8'h11, 8'h00}, 0, '0};
        tbl[2] = '{3, 6, {8'h00, 8'h00, 8'hBB, 8'hAA, 8'h07}, '0, 2, {3'd0, 3'd0, 3'd0, 3'd7}};
        tbl[3] = '{3, 6, {8'h00, 8'h00, 8'h00, 8'h00, 8'h87}, {8'h00, 8'h00, 8'hBB, 8'hAA, 8'h00}, 0, '0};
        tbl[4] = '{5, 4, {8'hFE, 8'h01, 8'h5A, 8'hC3, 8'h03}, '0, 4, {3'd6, 3'd5, 3'd4, 3'd3}};
        tbl[5] = '{5, 4, {8'h00, 8'h00, 8'h00, 8'h00, 8'h83}, {8'hFE, 8'h01, 8'h5A, 8'hC3, 8'h00}, 0, '0};

        rst_n      = 1'b0;
        sif.sck_i  = 1'b0;
        sif.cs_n_i = 1'b1;
        sif.mosi_i = 1'b0;
        wait_clks(3);
        chk("rst_regs", regs_o, 64'h0);
        chk("rst_miso", {63'h0, sif.miso_o}, 64'h0);
        chk("rst_oe", {63'h0, sif.miso_oe}, 64'h0);
        chk("rst_strobe", {63'h0, wr_strobe_o}, 64'h0);
        chk("rst_waddr", {61'h0, wr_addr_o}, 64'h0);
        chk("rst_busy", {63'h0, busy_o}, 64'h0);
        rst_n = 1'b1;
        wait_clks(4);
        chk("idle_busy", {63'h0, busy_o}, 64'h0);

        for (int v = 0; v < 6; v++) begin
            stb0   = stb_cnt;
            cur_tx = tbl[v].tx;
            do_frame(tbl[v].nb * 8, tbl[v].hp, 1'b1);
            for (int b = 0; b < tbl[v].nb; b++)
                chk($sformatf("v%0d_miso_b%0d", v, b), {56'h0, cur_rx[b]}, {56'h0, tbl[v].exp_rx[b]});
            chk($sformatf("v%0d_oe", v), 64'(oe_bad), 64'h0);
            chk($sformatf("v%0d_nstb", v), 64'(stb_cnt - stb0), 64'(tbl[v].nstb));
            for (int s = 0; s < tbl[v].nstb; s++)
                chk($sformatf("v%0d_saddr%0d", v, s), {61'h0, stb_log[stb0+s]}, {61'h0, tbl[v].saddr[s]});
            chk($sformatf("v%0d_busy_after", v), {63'h0, busy_o}, 64'h0);
        end
        chk("regs_after_table", regs_o, 64'hAAFE015AC31100BB);

        // abort mid-byte: the partial 0xF0 must not reach reg1
        cur_tx = {8'h00, 8'h00, 8'h00, 8'h5C, 8'h01};
        do_frame(16, 6, 1'b1);
        chk("pre_abort_reg1", {56'h0, regs_o[15:8]}, 64'h5C);
        stb0   = stb_cnt;
        cur_tx = {8'h00, 8'h00, 8'h00, 8'hF0, 8'h01};
        do_frame(13, 6, 1'b1);
        chk("abort_nstb", 64'(stb_cnt - stb0), 64'h0);
        chk("abort_reg1", {56'h0, regs_o[15:8]}, 64'h5C);
        chk("abort_busy", {63'h0, busy_o}, 64'h0);
        cur_tx = {8'h00, 8'h00, 8'h00, 8'h00, 8'h81};
        do_frame(16, 6, 1'b1);
        chk("abort_readback", {56'h0, cur_rx[1]}, 64'h5C);

        // asynchronous reset in the middle of a read
        cur_tx = {8'h00, 8'h00, 8'h00, 8'h00, 8'h80};
        do_frame(12, 6, 1'b0);
        wait_clks(2);
        chk("midread_busy", {63'h0, busy_o}, 64'h1);
        #2 rst_n = 1'b0;
        #1;
        chk("arst_regs", regs_o, 64'h0);
        chk("arst_busy", {63'h0, busy_o}, 64'h0);
        chk("arst_oe", {63'h0, sif.miso_oe}, 64'h0);
        chk("arst_miso", {63'h0, sif.miso_o}, 64'h0);
        chk("arst_strobe", {63'h0, wr_strobe_o}, 64'h0);
        chk("arst_waddr", {61'h0, wr_addr_o}, 64'h0);
        sif.cs_n_i = 1'b1;
        sif.sck_i  = 1'b0;
        wait_clks(3);
        rst_n = 1'b1;
        wait_clks(4);
        chk("post_arst_busy", {63'h0, busy_o}, 64'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
